// File: rtl/bp_cfg_loader_pkg.sv
// Shared types for the boot-table cfg loader: table entry layout, FSM states
// and the end-of-table sentinel address.
package bp_cfg_loader_pkg;

  localparam int unsigned cfg_addr_width_lp = 16;
  localparam int unsigned cfg_data_width_lp = 32;

  typedef struct packed {
    logic [cfg_addr_width_lp-1:0] addr;
    logic [cfg_data_width_lp-1:0] data;
  } bp_cfg_entry_s;

  // An all-ones register address never names a real cfg register.
  localparam logic [cfg_addr_width_lp-1:0] cfg_sentinel_addr = '1;

  typedef enum logic [2:0] {
    e_idle,
    e_fetch,
    e_check,
    e_send,
    e_drain,
    e_done
  } bp_cfg_state_e;

endpackage

// File: rtl/bp_cfg_credit_counter.sv
// Available-credit counter for outstanding cfg writes: starts full, counts
// down on each write and back up on each acknowledgement, saturating at both ends.
module bp_cfg_credit_counter #(
  parameter int unsigned max_credits = 4,
  localparam int unsigned cnt_width  = $clog2(max_credits + 1)
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  logic [cnt_width-1:0] count_q;

  assign full_o  = (count_q == cnt_width'(max_credits));
  assign empty_o = (count_q == '0);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= cnt_width'(max_credits);
    end else if (inc_i && !dec_i && !full_o) begin
      count_q <= count_q + cnt_width'(1);
    end else if (dec_i && !inc_i && !empty_o) begin
      count_q <= count_q - cnt_width'(1);
    end
  end

  // A return with every credit already home means the responder side lost
  // track of outstanding writes.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(inc_i && !dec_i && full_o));
    end
  end

endmodule

// File: rtl/bp_cfg_loader.sv
// Boot-table cfg loader: reads (addr, data) entries from a synchronous ROM and
// broadcasts each one as a cfg write to every core, throttled by write credits.
module bp_cfg_loader
  import bp_cfg_loader_pkg::*;
#(
  parameter int unsigned num_core       = 1,
  parameter int unsigned cfg_core_width = 8,
  parameter int unsigned cfg_addr_width = 16,
  parameter int unsigned cfg_data_width = 32,
  parameter int unsigned max_credits    = 4,
  parameter int unsigned rom_els        = 256,
  localparam int unsigned lg_rom_els    = $clog2(rom_els)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   start_i,
  output logic [lg_rom_els-1:0]                  rom_addr_o,
  input  logic [cfg_addr_width+cfg_data_width-1:0] rom_data_i,
  output logic                                   cfg_v_o,
  input  logic                                   cfg_ready_i,
  output logic [cfg_core_width-1:0]              cfg_core_o,
  output logic [cfg_addr_width-1:0]              cfg_addr_o,
  output logic [cfg_data_width-1:0]              cfg_data_o,
  input  logic                                   credit_return_i,
  output logic                                   busy_o,
  output logic                                   done_o
);

  localparam int unsigned core_cnt_width = (num_core > 1) ? $clog2(num_core) : 1;

  if (num_core < 1 || num_core > (1 << cfg_core_width)) begin : g_bad_num_core
    $error("bp_cfg_loader: num_core must be in 1..2**cfg_core_width");
  end
  if (cfg_addr_width != cfg_addr_width_lp || cfg_data_width != cfg_data_width_lp) begin : g_bad_entry
    $error("bp_cfg_loader: cfg widths must match the bp_cfg_entry_s layout");
  end

  bp_cfg_state_e             state_q, state_n;
  logic [lg_rom_els-1:0]     index_q, index_n;
  logic [core_cnt_width-1:0] core_q, core_n;
  bp_cfg_entry_s             entry_q, entry_n;
  bp_cfg_entry_s             rom_entry;

  logic credits_full, credits_empty;
  logic xfer, last_core, last_index;

  assign rom_entry  = bp_cfg_entry_s'(rom_data_i);
  assign xfer       = cfg_v_o & cfg_ready_i;
  assign last_core  = (core_q == core_cnt_width'(num_core - 1));
  assign last_index = (index_q == lg_rom_els'(rom_els - 1));

  bp_cfg_credit_counter #(
    .max_credits(max_credits)
  ) u_credits (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .inc_i    (credit_return_i),
    .dec_i    (xfer),
    .full_o   (credits_full),
    .empty_o  (credits_empty)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      index_q <= '0;
      core_q  <= '0;
      entry_q <= '0;
    end else begin
      state_q <= state_n;
      index_q <= index_n;
      core_q  <= core_n;
      entry_q <= entry_n;
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_n = state_q;
    index_n = index_q;
    core_n  = core_q;
    entry_n = entry_q;
    unique case (state_q)
      e_idle, e_done: begin
        if (start_i) begin
          state_n = e_fetch;
          index_n = '0;
        end
      end
      // The ROM registers rom_addr_o at the end of FETCH, so its data is
      // valid during CHECK and is captured on the way into SEND.
      e_fetch: state_n = e_check;
      e_check: begin
        entry_n = rom_entry;
        if (rom_entry.addr == cfg_sentinel_addr) begin
          state_n = e_drain;
        end else begin
          core_n  = '0;
          state_n = e_send;
        end
      end
      e_send: begin
        if (xfer) begin
          core_n = core_q + core_cnt_width'(1);
          if (last_core) begin
            if (last_index) begin
              state_n = e_drain;
            end else begin
              index_n = index_q + lg_rom_els'(1);
              state_n = e_fetch;
            end
          end
        end
      end
      e_drain: begin
        if (credits_full) state_n = e_done;
      end
      default: state_n = e_idle;
    endcase
  end

  assign rom_addr_o = index_q;
  assign cfg_v_o    = (state_q == e_send) & ~credits_empty;
  assign cfg_core_o = cfg_core_width'(core_q);
  assign cfg_addr_o = entry_q.addr;
  assign cfg_data_o = entry_q.data;
  assign busy_o     = (state_q == e_fetch) | (state_q == e_check) |
                      (state_q == e_send)  | (state_q == e_drain);
  assign done_o     = (state_q == e_done);

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Directed self-checking bench for bp_cfg_loader with num_core=2, max_credits=4
// and a 256-entry ROM model.
module tb_bp_cfg_loader;

  localparam int num_core    = 2;
  localparam int max_credits = 4;
  localparam int rom_els     = 256;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  rom_addr_o;
  logic [47:0] rom_data_i = '0;
  logic        cfg_v_o;
  logic        cfg_ready_i = 1'b0;
  logic [7:0]  cfg_core_o;
  logic [15:0] cfg_addr_o;
  logic [31:0] cfg_data_o;
  logic        credit_return_i = 1'b0;
  logic        busy_o;
  logic        done_o;

  logic [47:0] rom [rom_els];

  bp_cfg_loader #(
    .num_core   (num_core),
    .max_credits(max_credits),
    .rom_els    (rom_els)
  ) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .start_i        (start_i),
    .rom_addr_o     (rom_addr_o),
    .rom_data_i     (rom_data_i),
    .cfg_v_o        (cfg_v_o),
    .cfg_ready_i    (cfg_ready_i),
    .cfg_core_o     (cfg_core_o),
    .cfg_addr_o     (cfg_addr_o),
    .cfg_data_o     (cfg_data_o),
    .credit_return_i(credit_return_i),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous boot ROM: one-cycle read latency.
  always @(posedge clk_i) rom_data_i <= rom[rom_addr_o];

  int          total = 0;
  int          bad = 0;
  logic [55:0] xlog[$];   // {core, addr, data} of each transfer, in order
  logic [1:0]  pend = '0;
  bit          auto_ret = 1'b0;
  int          n_ret = 0;
  int          waited;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; log the transfer/return taking effect at this edge and
  // schedule auto credit returns two cycles after each transfer.
  task automatic step();
    bit x;
    x = cfg_v_o && cfg_ready_i;
    if (x) xlog.push_back({cfg_core_o, cfg_addr_o, cfg_data_o});
    if (credit_return_i) n_ret++;
    @(posedge clk_i);
    @(negedge clk_i);
    credit_return_i = auto_ret && pend[1];
    pend = {pend[0], x};
  endtask

  task automatic start_load();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset_n_i = 1'b0;
    start_i = 1'b0;
    credit_return_i = 1'b0;
    pend = '0;
    #1;
    check({tag, "_v"},    64'(cfg_v_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd0);
    check({tag, "_raddr"}, 64'(rom_addr_o), 64'd0);
    check({tag, "_core"}, 64'(cfg_core_o), 64'd0);
    check({tag, "_addr"}, 64'(cfg_addr_o), 64'd0);
    check({tag, "_data"}, 64'(cfg_data_o), 64'd0);
    check({tag, "_cred"}, 64'(dut.u_credits.count_q), 64'd4);
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    foreach (rom[i]) rom[i] = {16'h0100 + 16'(i), 32'(i)};

    @(negedge clk_i);
    do_reset("rst0");
    step();
    step();
    check("idle_busy", 64'(busy_o), 64'd0);
    check("idle_done", 64'(done_o), 64'd0);

    // Two entries then sentinel, ready always high, credits back after 2 cycles.
    rom[0] = {16'h0010, 32'hA};
    rom[1] = {16'h0020, 32'hB};
    rom[2] = {16'hFFFF, 32'h0};
    cfg_ready_i = 1'b1;
    auto_ret = 1'b1;
    n_ret = 0;
    xlog.delete();
    start_load();
    check("t1_busy_run", 64'(busy_o), 64'd1);
    check("t1_raddr0", 64'(rom_addr_o), 64'd0);
    waited = 0;
    while (!done_o && waited < 100) begin
      step();
      waited++;
    end
    check("t1_done", 64'(done_o), 64'd1);
    check("t1_busy_end", 64'(busy_o), 64'd0);
    check("t1_returns", 64'(n_ret), 64'd4);
    check("t1_nxfer", 64'(xlog.size()), 64'd4);
    if (xlog.size() == 4) begin
      check("t1_w0", 64'(xlog[0]), 64'({8'd0, 16'h0010, 32'hA}));
      check("t1_w1", 64'(xlog[1]), 64'({8'd1, 16'h0010, 32'hA}));
      check("t1_w2", 64'(xlog[2]), 64'({8'd0, 16'h0020, 32'hB}));
      check("t1_w3", 64'(xlog[3]), 64'({8'd1, 16'h0020, 32'hB}));
    end

    // Credits never returned: four writes, then stall; one return frees one write.
    rom[0] = {16'h0100, 32'd0};
    rom[1] = {16'h0101, 32'd1};
    rom[2] = {16'h0102, 32'd2};
    auto_ret = 1'b0;
    xlog.delete();
    start_load();
    repeat (40) step();
    check("t2_nxfer4", 64'(xlog.size()), 64'd4);
    check("t2_v_low", 64'(cfg_v_o), 64'd0);
    check("t2_busy", 64'(busy_o), 64'd1);
    check("t2_cred0", 64'(dut.u_credits.count_q), 64'd0);
    if (xlog.size() == 4) check("t2_w3", 64'(xlog[3]), 64'({8'd1, 16'h0101, 32'd1}));
    credit_return_i = 1'b1;
    step();
    repeat (20) step();
    check("t2_nxfer5", 64'(xlog.size()), 64'd5);
    check("t2_v_low2", 64'(cfg_v_o), 64'd0);
    if (xlog.size() == 5) check("t2_w4", 64'(xlog[4]), 64'({8'd0, 16'h0102, 32'd2}));

    // Ready low mid-entry, then transfer together with a credit return.
    do_reset("rst1");
    cfg_ready_i = 1'b0;
    xlog.delete();
    start_load();
    waited = 0;
    while (!cfg_v_o && waited < 10) begin
      step();
      waited++;
    end
    check("t3_v_up", 64'(cfg_v_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold_v", 64'(cfg_v_o), 64'd1);
      check("t3_hold_f", 64'({cfg_core_o, cfg_addr_o, cfg_data_o}), 64'({8'd0, 16'h0100, 32'd0}));
      check("t3_hold_cred", 64'(dut.u_credits.count_q), 64'd4);
    end
    cfg_ready_i = 1'b1;
    step();
    check("t3_cred3", 64'(dut.u_credits.count_q), 64'd3);
    step();
    check("t3_cred2", 64'(dut.u_credits.count_q), 64'd2);
    check("t3_nxfer2", 64'(xlog.size()), 64'd2);
    check("t3_bubble_v", 64'(cfg_v_o), 64'd0);
    step();
    step();
    check("t3_e1_v", 64'(cfg_v_o), 64'd1);
    check("t3_e1_addr", 64'(cfg_addr_o), 64'h0101);
    credit_return_i = 1'b1;
    step();
    check("t3_same_cyc_cred", 64'(dut.u_credits.count_q), 64'd2);
    check("t3_nxfer3", 64'(xlog.size()), 64'd3);
    check("t3_pre_rst_v", 64'(cfg_v_o), 64'd1);
    do_reset("rst_send");
    xlog.delete();
    start_load();
    check("t3_restart_raddr", 64'(rom_addr_o), 64'd0);
    waited = 0;
    while (!cfg_v_o && waited < 10) begin
      step();
      waited++;
    end
    check("t3_restart_f", 64'({cfg_v_o, cfg_core_o, cfg_addr_o, cfg_data_o}),
          64'({1'b1, 8'd0, 16'h0100, 32'd0}));

    // Sentinel at index 0: no writes, done within three cycles of start.
    do_reset("rst2");
    rom[0] = {16'hFFFF, 32'h5};
    auto_ret = 1'b1;
    xlog.delete();
    start_load();
    waited = 0;
    while (!done_o && waited < 3) begin
      step();
      waited++;
    end
    check("t4_done", 64'(done_o), 64'd1);
    check("t4_busy", 64'(busy_o), 64'd0);
    check("t4_nxfer", 64'(xlog.size()), 64'd0);

    // Full table with no sentinel: all 256 entries broadcast, then done.
    rom[0] = {16'h0100, 32'd0};
    xlog.delete();
    start_load();
    waited = 0;
    while (!done_o && waited < 3000) begin
      step();
      waited++;
    end
    check("t5_done", 64'(done_o), 64'd1);
    check("t5_nxfer", 64'(xlog.size()), 64'd512);
    check("t5_raddr", 64'(rom_addr_o), 64'hFF);
    check("t5_cred", 64'(dut.u_credits.count_q), 64'd4);
    if (xlog.size() == 512) begin
      check("t5_w510", 64'(xlog[510]), 64'({8'd0, 16'h01FF, 32'd255}));
      check("t5_w511", 64'(xlog[511]), 64'({8'd1, 16'h01FF, 32'd255}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
